// File: rtl/gf163_mul_ctrl.sv
// Sequencer for the 8-digit systolic GF(2^163) multiplier array: latches A, streams B
// MSB-first one digit per clock, then captures the array's accumulator as the product.
module gf163_mul_ctrl #(
    parameter int unsigned M      = 163,
    parameter int unsigned DIGITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic [M-1:0]      a_in,
    input  logic [M-1:0]      b_in,
    output logic              ready_out,
    output logic              busy_out,
    output logic [M-1:0]      a_out,
    output logic [DIGITS-1:0] b_digit_out,
    output logic              acc_clr_out,
    output logic              acc_en_out,
    input  logic [M-1:0]      t_in,
    output logic [M-1:0]      c_out,
    output logic              done_out
);

    localparam int unsigned NDIG = (M + DIGITS - 1) / DIGITS;
    localparam int unsigned BW   = DIGITS * NDIG;
    localparam int unsigned CW   = $clog2(NDIG);
    localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CAPT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [BW-1:0]   bsr_q,   bsr_d;
    logic [M-1:0]    a_q,     a_d;
    logic [M-1:0]    c_q,     c_d;
    logic            done_q,  done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bsr_q   <= '0;
            a_q     <= '0;
            c_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bsr_q   <= bsr_d;
            a_q     <= a_d;
            c_q     <= c_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bsr_d   = bsr_q;
        a_d     = a_q;
        c_d     = c_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_in) begin
                    a_d     = a_in;
                    // B is zero-extended at the top so the first digit carries the pad bits
                    bsr_d   = BW'(b_in);
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort_in) begin
                    state_d = IDLE;
                end else begin
                    bsr_d = bsr_q << DIGITS;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = CAPT;
                    end
                end
            end
            CAPT: begin
                if (abort_in) begin
                    state_d = IDLE;
                end else begin
                    c_d     = t_in;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ready_out   = (state_q == IDLE);
        busy_out    = (state_q == RUN) || (state_q == CAPT);
        acc_en_out  = (state_q == RUN);
        acc_clr_out = (state_q == RUN) && (cnt_q == '0);
        b_digit_out = (state_q == RUN) ? bsr_q[BW-1 -: DIGITS] : '0;
    end

    assign a_out    = a_q;
    assign c_out    = c_q;
    assign done_out = done_q;

endmodule
